tick_period_meter: RTL and testbench

- Measures the interval, in `clk` cycles, between consecutive rising edges of a tick or pulse input.
- Presents each measurement on a valid/ready output with a one-entry buffer.
- It is the receive-side counterpart of the team's divided-clock tick generator: a generator programmed with divisor N (tick every N+1 cycles) is read back by this block as `period` = N.
- Used for loop-back self-test of tick generators, and for frequency/period measurement of external strobes feeding the Nios-visible status registers.

---
 rtl/tick_meter_pkg.sv | 26 ++
 rtl/sync_rise_detect.sv | 67 ++++++
 rtl/tick_period_meter.sv | 173 +++++++++++++++++
 tb/tb_tick_period_meter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_meter_pkg.sv
//------------------------------------------------------------------------------
// Module  : tick_meter_pkg
// Purpose : Shared types and constants for the tick period meter.
//           - meter_state_t : measurement FSM states
//           - SYNC_MAX      : deepest supported input synchronizer
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tick_meter_pkg;

    // Deepest input synchronizer the front end will build.
    localparam int SYNC_MAX = 3;

    // IDLE    : disabled, counter and lock cleared
    // ARMED   : waiting for the first edge of a measurement run
    // MEASURE : counting clk cycles between consecutive edges
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

endpackage : tick_meter_pkg

`default_nettype wire

// File: rtl/sync_rise_detect.sv
//------------------------------------------------------------------------------
// Module  : sync_rise_detect
// Purpose : Brings tick_in into the clk domain through an optional
//           flip-flop chain and flags its rising edges.
// Ports   : clk     - clock
//           rst     - synchronous active-high reset
//           tick_in - asynchronous (or same-clock) pulse input
//           rise    - one-cycle flag: synchronized input went 0 -> 1
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_rise_detect
    import tick_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic rise
);

    // Requests deeper than the supported chain are clamped.
    localparam int c_DEPTH = (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;

    logic w_synced;
    logic r_prev;

    generate
        if (c_DEPTH == 0) begin : g_bypass
            // Same-clock source: no metastability protection needed.
            assign w_synced = tick_in;
        end else begin : g_sync
            logic [c_DEPTH-1:0] r_sync;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= tick_in;
                    for (int i = 1; i < c_DEPTH; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_synced = r_sync[c_DEPTH-1];
        end
    endgenerate

    // prev follows the synchronized input at all times (independent of any
    // enable upstream), so a level that is already high never looks like a
    // fresh edge later on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_synced;
        end
    end

    assign rise = w_synced & ~r_prev;

endmodule : sync_rise_detect

`default_nettype wire

// File: rtl/tick_period_meter.sv
//------------------------------------------------------------------------------
// Module  : tick_period_meter
// Purpose : Measures the number of clk cycles between consecutive rising
//           edges of tick_in and reports (gap - 1) through a one-entry
//           valid/ready buffer. Detects loss of tick and a stable period.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           en            - measurement enable
//           tick_in       - pulse/strobe being measured
//           timeout       - max count before loss-of-tick (0 = disabled)
//           period        - measured edge-to-edge gap minus one
//           period_valid  - period holds an unconsumed result
//           period_ready  - consumer accepts period
//           overrun       - pulse: result dropped, buffer full
//           timed_out     - pulse: count reached timeout without an edge
//           locked        - last two captured results were equal
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int WIDTH       = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] timeout,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             timed_out,
    output logic             locked
);

    localparam logic [WIDTH-1:0] c_CNT_MAX = {WIDTH{1'b1}};

    meter_state_t     r_state;
    meter_state_t     w_next_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_last;
    logic             r_last_vld;
    logic             r_valid;
    logic             r_overrun;
    logic             r_timed_out;
    logic             r_locked;
    logic             w_rise;
    logic             w_capture;
    logic             w_timeout;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rise_detect (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .rise    (w_rise)
    );

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                // First edge only starts the run; there is no gap yet.
                if (w_rise) begin
                    w_next_state = MEASURE;
                end
            end
            MEASURE: begin
                // An edge beats a timeout landing on the same cycle.
                if (w_rise) begin
                    w_capture = 1'b1;
                end else if ((timeout != '0) && (r_cnt == timeout)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ARMED;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Disabling overrides everything, but a capture on this cycle
        // still completes.
        if (!en) begin
            w_next_state = IDLE;
        end
    end

    //--------------------------------------------------------------------------
    // Saturating gap counter: restarts on every edge, holds at all-ones
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state != MEASURE) || w_capture || w_timeout) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Output buffer, status pulses and lock compare
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period    <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_timed_out <= 1'b0;
            r_locked    <= 1'b0;
            r_last      <= '0;
            r_last_vld  <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_timed_out <= w_timeout;
            if (w_capture) begin
                if (!r_valid || period_ready) begin
                    r_period <= r_cnt;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
                // Dropped results still feed the lock comparison so lock
                // tracks the source, not the consumer.
                r_locked   <= r_last_vld && (r_cnt == r_last);
                r_last     <= r_cnt;
                r_last_vld <= 1'b1;
            end else begin
                if (r_valid && period_ready) begin
                    r_valid <= 1'b0;
                end
                // A new run (after idle or loss of tick) starts with no
                // reference result.
                if (w_timeout || (r_state == IDLE)) begin
                    r_locked   <= 1'b0;
                    r_last_vld <= 1'b0;
                end
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign overrun      = r_overrun;
    assign timed_out    = r_timed_out;
    assign locked       = r_locked;

endmodule : tick_period_meter

`default_nettype wire

// File: tb/tb_tick_period_meter.sv
//------------------------------------------------------------------------------
// Module  : tb_tick_period_meter
// Purpose : Self-checking bench for tick_period_meter. Two instances (no
//           synchronizer and a 2-stage synchronizer) share all inputs and
//           are compared every cycle against a cycle-number based model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_period_meter;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;
    localparam int HIST = 16384;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         tick_in;
    logic         ready;
    logic [W-1:0] timeout;

    logic [W-1:0] period0, period2;
    logic         valid0, valid2, ovr0, ovr2, to0, to2, lock0, lock2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tick_period_meter #(.WIDTH(W), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .timeout(timeout),
        .period(period0), .period_valid(valid0), .period_ready(ready),
        .overrun(ovr0), .timed_out(to0), .locked(lock0)
    );

    tick_period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .timeout(timeout),
        .period(period2), .period_valid(valid2), .period_ready(ready),
        .overrun(ovr2), .timed_out(to2), .locked(lock2)
    );

    //--------------------------------------------------------------------------
    // Reference model. Cycle c is the cycle ending at the c-th posedge.
    // The synchronized input at cycle c is tick_in as seen S cycles earlier;
    // intervals are computed from the cycle numbers of the edges.
    //--------------------------------------------------------------------------
    bit           tick_hist [HIST];
    int           cyc   = 0;
    int           rbase = 0;
    int           m_mode [2];     // 0 idle, 1 armed, 2 measuring
    int           m_last [2];     // cycle number of most recent edge
    bit           m_have [2];
    int           m_prevres [2];
    logic [W-1:0] m_per [2];
    bit           m_val [2];
    bit           m_ovr [2];
    bit           m_to [2];
    bit           m_lock [2];

    function automatic int stages(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic bit synced_at(int k, int c);
        if (c - stages(k) < rbase) return 1'b0;
        return tick_hist[c - stages(k)];
    endfunction

    always @(posedge clk) begin
        int c;
        bit s_now, s_prev, rise, cap;
        int cnt, nm;
        c = cyc;
        tick_hist[c % HIST] = tick_in;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0; m_per[k] = '0; m_val[k] = 0; m_ovr[k] = 0;
                m_to[k] = 0; m_lock[k] = 0; m_have[k] = 0;
            end
            rbase = c + 1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                s_now  = synced_at(k, c);
                s_prev = (c - 1 >= rbase) ? synced_at(k, c - 1) : 1'b0;
                rise   = s_now & ~s_prev;
                m_ovr[k] = 0;
                m_to[k]  = 0;
                cap = 0;
                cnt = 0;
                nm  = m_mode[k];
                case (m_mode[k])
                    0: begin
                        m_lock[k] = 0;
                        m_have[k] = 0;
                        if (en) nm = 1;
                    end
                    1: begin
                        if (rise) begin m_last[k] = c; nm = 2; end
                    end
                    default: begin
                        cnt = c - m_last[k] - 1;
                        if (cnt > MAXV) cnt = MAXV;
                        if (rise) begin
                            cap = 1;
                            m_last[k] = c;
                        end else if (timeout != 0 && cnt == int'(timeout)) begin
                            m_to[k] = 1; m_lock[k] = 0; m_have[k] = 0; nm = 1;
                        end
                    end
                endcase
                if (!en) nm = 0;
                if (cap) begin
                    if (!m_val[k] || ready) begin
                        m_per[k] = W'(cnt);
                        m_val[k] = 1;
                    end else begin
                        m_ovr[k] = 1;
                    end
                    m_lock[k]    = m_have[k] && (cnt == m_prevres[k]);
                    m_prevres[k] = cnt;
                    m_have[k]    = 1;
                end else if (m_val[k] && ready) begin
                    m_val[k] = 0;
                end
                m_mode[k] = nm;
            end
        end
        cyc = c + 1;
    end

    wire [W+3:0] obs0 = {period0, valid0, ovr0, to0, lock0};
    wire [W+3:0] obs2 = {period2, valid2, ovr2, to2, lock2};
    wire [W+3:0] exp0 = {m_per[0], m_val[0], m_ovr[0], m_to[0], m_lock[0]};
    wire [W+3:0] exp2 = {m_per[1], m_val[1], m_ovr[1], m_to[1], m_lock[1]};

    //--------------------------------------------------------------------------
    // Stimulus helpers (drive only)
    //--------------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1; en = 1'b0; tick_in = 1'b0; ready = 1'b1; timeout = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input logic [W-1:0] to_val, input logic rdy);
        do_reset();
        timeout = to_val; ready = rdy; en = 1'b1; tick_in = 1'b0;
        @(negedge clk);
    endtask

    //--------------------------------------------------------------------------
    // Tests
    //--------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; tick_in = 1'b1; ready = 1'b0; timeout = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({obs0, obs2} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got dut0=%h dut2=%h, required all zero", obs0, obs2);
        end
        n_checks++;
        if ({obs0, obs2} !== {exp0, exp2}) begin
            n_errors++;
            $display("FAIL reset_model: got %h/%h, required %h/%h", obs0, obs2, exp0, exp2);
        end
        rst = 1'b0; tick_in = 1'b0;
    endtask

    task automatic test_loopback();
        int nres = 0;
        start_run('0, 1'b1);
        for (int i = 0; i < 48; i++) begin
            tick_in = (i % 4 == 0);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL loopback_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            if (valid0) begin
                nres++;
                n_checks++;
                if (period0 !== 8'd3 || (nres >= 2 && lock0 !== 1'b1)) begin
                    n_errors++;
                    $display("FAIL loopback_value i=%0d: got period=%0d locked=%b, required 3 and locked from 2nd", i, period0, lock0);
                end
            end
        end
        n_checks++;
        if (nres != 11) begin
            n_errors++;
            $display("FAIL loopback_count: got %0d results, required 11", nres);
        end
    endtask

    task automatic test_back_to_back();
        int nres = 0;
        start_run('0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick_in = (i % 2 == 0);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL b2b_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            if (valid0) begin
                nres++;
                n_checks++;
                if (period0 !== 8'd1) begin
                    n_errors++;
                    $display("FAIL b2b_period i=%0d: got %0d, required 1", i, period0);
                end
            end
        end
        n_checks++;
        if (nres != 9 || lock0 !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d results locked=%b, required 9 locked=1", nres, lock0);
        end
    endtask

    task automatic test_backpressure();
        int novr = 0;
        start_run('0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick_in = (i % 6 == 0);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL bp_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            if (ovr0) novr++;
            n_checks++;
            if (valid0 !== (i >= 6) || (i >= 6 && period0 !== 8'd5)) begin
                n_errors++;
                $display("FAIL bp_hold i=%0d: got valid=%b period=%0d, required valid=%b period=5", i, valid0, period0, (i >= 6));
            end
        end
        n_checks++;
        if (novr != 2) begin
            n_errors++;
            $display("FAIL bp_overrun: got %0d pulses, required 2", novr);
        end
        ready = 1'b1; tick_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid0 !== 1'b0 || {obs0, obs2} !== {exp0, exp2}) begin
            n_errors++;
            $display("FAIL bp_release: got valid=%b (%h/%h), required 0 (%h/%h)", valid0, obs0, obs2, exp0, exp2);
        end
    endtask

    task automatic test_timeout();
        int nto = 0;
        int to_at = -1;
        start_run(8'd10, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick_in = (i == 0);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL timeout_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            if (to0) begin nto++; to_at = i; end
        end
        n_checks++;
        if (nto != 1 || to_at != 11 || lock0 !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_pulse: got %0d pulses at i=%0d locked=%b, required 1 at i=11 locked=0", nto, to_at, lock0);
        end
        for (int j = 0; j < 12; j++) begin
            tick_in = (j == 0 || j == 7);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL timeout_rearm_model j=%0d: got %h/%h, required %h/%h", j, obs0, obs2, exp0, exp2);
            end
            if (j <= 7) begin
                n_checks++;
                if (valid0 !== (j == 7) || (j == 7 && period0 !== 8'd6)) begin
                    n_errors++;
                    $display("FAIL timeout_rearm j=%0d: got valid=%b period=%0d, required valid=%b period=6", j, valid0, period0, (j == 7));
                end
            end
        end
    endtask

    task automatic test_const_high();
        int nto = 0;
        start_run(8'd10, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick_in = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2} || valid0 !== 1'b0) begin
                n_errors++;
                $display("FAIL const_high i=%0d: got %h/%h, required %h/%h with valid=0", i, obs0, obs2, exp0, exp2);
            end
            if (to0) nto++;
        end
        n_checks++;
        if (nto != 1) begin
            n_errors++;
            $display("FAIL const_high_timeout: got %0d pulses, required 1", nto);
        end
        tick_in = 1'b0;
    endtask

    task automatic test_enable();
        start_run('0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            en      = !(i >= 3 && i <= 5);
            tick_in = (i == 0) || (i >= 5 && i <= 7) || (i == 10) || (i == 15);
            ready   = (i < 15);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL enable_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            n_checks++;
            if (valid0 !== (i >= 15) || (i >= 15 && period0 !== 8'd4)) begin
                n_errors++;
                $display("FAIL enable_gap i=%0d: got valid=%b period=%0d, required valid=%b period=4", i, valid0, period0, (i >= 15));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({obs0, obs2} !== '0) begin
            n_errors++;
            $display("FAIL reset_with_valid: got %h/%h, required all zero", obs0, obs2);
        end
        rst = 1'b0; ready = 1'b1; tick_in = 1'b0;
    endtask

    task automatic test_sync_latency();
        start_run('0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            tick_in = (i % 10 == 0);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL sync_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            if (i == 11 || i == 12) begin
                n_checks++;
                if (valid2 !== (i == 12) || (i == 12 && period2 !== 8'd9)) begin
                    n_errors++;
                    $display("FAIL sync_latency i=%0d: got valid=%b period=%0d, required valid=%b period=9", i, valid2, period2, (i == 12));
                end
            end
        end
    endtask

    task automatic test_saturation();
        start_run('0, 1'b1);
        for (int i = 0; i < 302; i++) begin
            tick_in = (i == 0 || i == 300);
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL sat_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
            if (i == 300) begin
                n_checks++;
                if (valid0 !== 1'b1 || period0 !== 8'hFF) begin
                    n_errors++;
                    $display("FAIL saturation: got valid=%b period=%h, required 1 and ff", valid0, period0);
                end
            end
        end
    endtask

    task automatic test_random();
        int mode = 0;
        int n    = 3;
        int ph   = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                mode    = $urandom_range(0, 2);
                n       = $urandom_range(1, 12);
                timeout = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(3, 20));
            end
            rst   = ($urandom_range(0, 499) == 0);
            en    = ($urandom_range(0, 39) != 0);
            ready = ($urandom_range(0, 3) != 0);
            if (mode == 0) begin
                tick_in = ($urandom_range(0, 3) == 0);
            end else begin
                tick_in = (ph == 0);
                ph = (ph >= n) ? 0 : ph + 1;
            end
            @(negedge clk);
            n_checks++;
            if ({obs0, obs2} !== {exp0, exp2}) begin
                n_errors++;
                $display("FAIL random_model i=%0d: got %h/%h, required %h/%h", i, obs0, obs2, exp0, exp2);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_const_high();
        test_enable();
        test_sync_latency();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tick_period_meter

`default_nettype wire
